// File: rtl/period_timer_pkg.sv
// period_timer shared types and constants.
// Overrun detection is built only with PERIOD_TIMER_OVERRUN_EN defined.
package period_timer_pkg;

  localparam int CNT_W = 20;

  localparam logic [CNT_W-1:0] PERIOD_RST = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic             periodic;
  } timer_cfg_t;

endpackage

// File: rtl/period_timer_if.sv
// Control and tick handshake bundle for period_timer.
// master = controller side, slave = timer side.
interface period_timer_if;
  import period_timer_pkg::*;

  logic             cfg_we;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_periodic;
  logic             start;
  logic             stop;
  logic             tick_valid;
  logic             tick_ack;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output cfg_we,
    output cfg_period,
    output cfg_periodic,
    output start,
    output stop,
    output tick_ack,
    output ovr_clr,
    input  tick_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  cfg_we,
    input  cfg_period,
    input  cfg_periodic,
    input  start,
    input  stop,
    input  tick_ack,
    input  ovr_clr,
    output tick_valid,
    output busy,
    output overrun
  );

endinterface

// File: rtl/period_timer_tick_hs.sv
// tick_hs: tick_valid/tick_ack register with optional sticky overrun.
// Overrun logic exists only with PERIOD_TIMER_OVERRUN_EN defined.
module tick_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic ack,
  input  logic flush,
  input  logic ovr_clr,
  output logic valid,
  output logic overrun
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

`ifdef PERIOD_TIMER_OVERRUN_EN
  logic ovr_set;

  // a new tick landing on an unacked one is lost
  assign ovr_set = set & valid & ~ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end
`else
  logic unused_ovr_clr;

  assign unused_ovr_clr = ovr_clr;
  assign overrun        = 1'b0;
`endif

endmodule

// File: rtl/period_timer.sv
// period_timer: one-shot/periodic tick control around up_counter.
// Optional overrun flag: define PERIOD_TIMER_OVERRUN_EN.
module period_timer
  import period_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  period_timer_if.slave    bus,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_sclr
);

  timer_state_t state_q;
  timer_state_t state_d;
  timer_cfg_t   cfg_q;

  logic hit;
  logic running;
  logic busy;
  logic tick_set;
  logic flush;
  logic tick_valid;
  logic overrun;

  always_comb begin
    hit      = (cnt_q == cfg_q.period);
    running  = (state_q == RUN);
    busy     = (state_q != IDLE);
    tick_set = running & hit & ~bus.stop;
    flush    = busy & bus.stop;
    cnt_sclr = ~running | hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (hit && !cfg_q.periodic) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (tick_valid && bus.tick_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // configuration is frozen while the timer is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q.period   <= PERIOD_RST;
      cfg_q.periodic <= 1'b0;
    end else if (!busy && bus.cfg_we) begin
      cfg_q.period   <= bus.cfg_period;
      cfg_q.periodic <= bus.cfg_periodic;
    end
  end

  tick_hs u_tick_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (tick_set),
    .ack     (bus.tick_ack),
    .flush   (flush),
    .ovr_clr (bus.ovr_clr),
    .valid   (tick_valid),
    .overrun (overrun)
  );

  assign bus.tick_valid = tick_valid;
  assign bus.busy       = busy;
  assign bus.overrun    = overrun;

endmodule

// File: tb/tb_period_timer.sv
// Directed bench for period_timer with a behavioural up_counter.
// Overrun expectations follow PERIOD_TIMER_OVERRUN_EN.
module tb_period_timer;
  import period_timer_pkg::*;

`ifdef PERIOD_TIMER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_sclr;

  int checks;
  int errors;

  period_timer_if bus ();

  period_timer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cnt_q    (cnt_q),
    .cnt_sclr (cnt_sclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // up_counter: no reset, clear on sclr, else increment
  initial cnt_q = 20'h00abc;
  always @(posedge clk) begin
    if (cnt_sclr) cnt_q <= '0;
    else          cnt_q <= cnt_q + 1'b1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CNT_W-1:0] n, input logic p);
    bus.cfg_period   = n;
    bus.cfg_periodic = p;
    bus.cfg_we       = 1'b1;
    step();
    bus.cfg_we       = 1'b0;
  endtask

  task automatic kick();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_period   = '0;
    bus.cfg_periodic = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.tick_ack     = 1'b0;
    bus.ovr_clr      = 1'b0;

    #1;
    check("rst_valid", 32'(bus.tick_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ovr", 32'(bus.overrun), 0);
    check("rst_sclr", 32'(cnt_sclr), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_q", cnt_q, 0);

    // one-shot N=5, stray ack before the tick
    load(20'd5, 1'b0);
    kick();
    check("os_busy0", 32'(bus.busy), 1);
    check("os_q0", cnt_q, 0);
    step();
    bus.tick_ack = 1'b1;
    step();
    bus.tick_ack = 1'b0;
    repeat (3) step();
    check("os_q5", cnt_q, 5);
    check("os_sclr_hit", 32'(cnt_sclr), 1);
    check("os_v_k5", 32'(bus.tick_valid), 0);
    step();
    check("os_v_k6", 32'(bus.tick_valid), 1);
    check("os_busy_hold", 32'(bus.busy), 1);
    check("os_q_hold", cnt_q, 0);
    repeat (2) step();
    check("os_v_held", 32'(bus.tick_valid), 1);
    bus.tick_ack = 1'b1;
    step();
    bus.tick_ack = 1'b0;
    check("os_v_ack", 32'(bus.tick_valid), 0);
    check("os_busy_ack", 32'(bus.busy), 0);

    // periodic N=3, ack every tick
    load(20'd3, 1'b1);
    kick();
    for (int i = 1; i <= 13; i++) begin
      step();
      check($sformatf("per_q%0d", i), cnt_q, 32'(i % 4));
      check($sformatf("per_v%0d", i), 32'(bus.tick_valid),
            32'((i >= 4) && (i % 4 == 0)));
      bus.tick_ack = (i >= 4) && (i % 4 == 0);
    end
    bus.tick_ack = 1'b0;
    bus.stop     = 1'b1;
    step();
    bus.stop     = 1'b0;
    check("per_stop_busy", 32'(bus.busy), 0);
    check("per_stop_v", 32'(bus.tick_valid), 0);

    // periodic N=2, no ack: merge and overrun
    load(20'd2, 1'b1);
    kick();
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("noack_v%0d", i), 32'(bus.tick_valid),
            32'(i >= 3));
      check($sformatf("noack_o%0d", i), 32'(bus.overrun),
            32'(OVR_EN && (i >= 6)));
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("noack_stop_v", 32'(bus.tick_valid), 0);
    check("noack_stop_o", 32'(bus.overrun), 32'(OVR_EN));
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    check("ovr_clr", 32'(bus.overrun), 0);

    // stop coincident with hit
    load(20'd4, 1'b0);
    kick();
    repeat (4) step();
    check("sh_q4", cnt_q, 4);
    check("sh_sclr", 32'(cnt_sclr), 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("sh_busy", 32'(bus.busy), 0);
    check("sh_v", 32'(bus.tick_valid), 0);
    check("sh_sclr_idle", 32'(cnt_sclr), 1);
    step();
    check("sh_v_late", 32'(bus.tick_valid), 0);

    // cfg_we and start while busy are ignored (N stays 4)
    kick();
    bus.cfg_period   = 20'd100;
    bus.cfg_periodic = 1'b1;
    bus.cfg_we       = 1'b1;
    bus.start        = 1'b1;
    step();
    bus.cfg_we       = 1'b0;
    bus.start        = 1'b0;
    repeat (3) step();
    check("ib_q4", cnt_q, 4);
    check("ib_v_k4", 32'(bus.tick_valid), 0);
    step();
    check("ib_v_k5", 32'(bus.tick_valid), 1);
    step();
    check("ib_hold_q", cnt_q, 0);
    check("ib_hold_busy", 32'(bus.busy), 1);
    bus.tick_ack = 1'b1;
    step();
    bus.tick_ack = 1'b0;
    check("ib_busy_ack", 32'(bus.busy), 0);

    // async reset mid-run at q=7
    load(20'd20, 1'b0);
    kick();
    repeat (7) step();
    check("ar_q7", cnt_q, 7);
    check("ar_sclr_run", 32'(cnt_sclr), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_sclr", 32'(cnt_sclr), 1);
    check("ar_busy", 32'(bus.busy), 0);
    check("ar_v", 32'(bus.tick_valid), 0);
    check("ar_ovr", 32'(bus.overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_q0", cnt_q, 0);
    check("ar_busy_rel", 32'(bus.busy), 0);

    // period restored to its reset value, not 20
    kick();
    repeat (20) step();
    check("ar_period", cnt_q, 20);
    check("ar_period_sclr", 32'(cnt_sclr), 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("ar_stop_busy", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
